adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter that time-shares one combinational `Adder` instance (N-bit, `s = a + b`) among R requesters in the CPU datapath, e.g. PC+4, branch-target and address-generation units. Each requester presents operands with a valid/ready handshake. The arbiter steers the granted operands onto the shared adder and captures the sum in a one-entry output register. The registered response carries the requester ID back to the consumer.

## Interface
- `N`, 32, operand and sum width in bits.
- `R`, 3, number of requesters; legal range 2..8.
- `IDW`, `$clog2(R)`, width of the requester ID (derived; not overridden).

- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  R  bit i: requester i presents operands.
- `req_ready`  out  R  bit i: requester i is granted and accepted this cycle; one-hot or zero.
- `req_a`  in  R*N  requester i operand A in bits [i*N +: N].
- `req_b`  in  R*N  requester i operand B in bits [i*N +: N].
- `add_a`  out  N  operand A driven to the shared `Adder`.
- `add_b`  out  N  operand B driven to the shared `Adder`.
- `add_s`  in  N  sum returned from the shared `Adder`; combinational.
- `rsp_valid`  out  1  the output register holds a result.
- `rsp_ready`  in  1  the consumer takes the result this cycle.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_sum`.
- `rsp_sum`  out  N  registered sum, modulo 2^N.

## Operation
- State:
  - `ptr` (IDW bits): priority pointer.
  - Output register: `rsp_valid`, `rsp_id`, `rsp_sum`.
  - Two-state view of the output register: EMPTY (`rsp_valid=0`), FULL (`rsp_valid=1`).
- `can_accept = !rsp_valid || rsp_ready`. A result can be replaced in the same cycle it drains.
- Grant `g`: the first i with `req_valid[i]=1`, scanning ptr, ptr+1, …, R-1, 0, …, ptr-1 (mod R).
- `req_ready[g] = can_accept`. All other `req_ready` bits are 0. If no request is valid, `req_ready` is 0.
- `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `ptr`. No requester may make `req_valid` depend on `req_ready`.
- `add_a`/`add_b` drive `req_a`/`req_b` of `g` whenever any request is valid, else 0. The operands are valid even when `can_accept=0`.
- On accept (`can_accept` and any valid):
  - `rsp_sum <= add_s`, `rsp_id <= g`, `rsp_valid <= 1`.
  - `ptr <= (g == R-1) ? 0 : g+1`.
- On drain without accept (`rsp_valid && rsp_ready` and no valid request): `rsp_valid <= 0`. `rsp_id` and `rsp_sum` hold their values.
- On stall (`rsp_valid && !rsp_ready`): all state holds and `req_ready` is 0.
- `ptr` changes only on accept, so an unserved requester keeps its priority.
- Arithmetic: `rsp_sum` is `(A + B) mod 2^N`. The carry-out is discarded. No signed interpretation is applied.
- Requester contract: after asserting `req_valid`, a requester holds `req_valid`, `req_a` and `req_b` stable until it sees `req_ready`. The arbiter does not check this.
- Fairness: with every requester continuously valid, each is granted exactly once in every R consecutive accepts.

## Timing
- Reset (async assert, synchronous-safe release): `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `ptr=0`, `req_ready=0`, `add_a=0`, `add_b=0`.
- Latency: an operand accepted at edge k appears on `rsp_*` after edge k. `rsp_valid` is high in cycle k+1.
- Throughput: one add per cycle while `rsp_ready` is held high.
- Reset mid-operation: any held result is lost and `ptr` returns to 0. After release, the first grant goes to the lowest-index valid requester.
- Simultaneous drain and accept: the new result replaces the old one in the same edge and `rsp_valid` stays 1.
- `ptr` wrap-around: after a grant to R-1, `ptr` returns to 0.

## Test plan
- Reset then single request: `req_valid=3'b010`, A=5, B=7, `rsp_ready=1` -> `req_ready=3'b010` in the same cycle; the next cycle shows `rsp_valid=1`, `rsp_id=1`, `rsp_sum=12`.
- Round-robin: all three requesters valid, `rsp_ready=1` for 6 cycles -> `rsp_id` sequence is 0,1,2,0,1,2.
- Backpressure: FULL with `rsp_ready=0` for 4 cycles while requester 2 is valid -> `req_ready=0`, `rsp_*` held; on `rsp_ready=1`, requester 2 is accepted in the same cycle and its sum appears in the next cycle.
- Overflow wrap: A=`32'hFFFF_FFFF`, B=`32'h0000_0002` -> `rsp_sum=32'h0000_0001`.
- Async reset mid-stream: assert `resetn=0` while FULL with `ptr=2` -> `rsp_valid` drops immediately; after release, with all three requesters valid, the first `rsp_id` is 0.
- Idle drain: FULL, no requests, `rsp_ready=1` -> `rsp_valid=0` in the next cycle while `rsp_sum` and `rsp_id` are unchanged.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Round-robin arbiter that time-shares one external combinational adder
//   (s = a + b, N bits) among R requesters. The granted requester's operands
//   are steered onto the adder, and the sum is captured together with the
//   requester ID in a one-entry output register.
//
// Ports
//   clk        : clock, rising edge
//   resetn     : asynchronous active-low reset
//   req_valid  : [R]    requester i presents operands
//   req_ready  : [R]    requester i accepted this cycle (one-hot or zero)
//   req_a      : [R*N]  operand A of requester i in [i*N +: N]
//   req_b      : [R*N]  operand B of requester i in [i*N +: N]
//   add_a      : [N]    operand A to the shared adder
//   add_b      : [N]    operand B to the shared adder
//   add_s      : [N]    sum from the shared adder (combinational)
//   rsp_valid  : output register holds a result
//   rsp_ready  : consumer takes the result this cycle
//   rsp_id     : [IDW]  requester that owns rsp_sum
//   rsp_sum    : [N]    registered sum, modulo 2^N
module adder_arbiter #(
  parameter  int N   = 32,
  parameter  int R   = 3,
  localparam int IDW = $clog2(R)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [R-1:0]     req_valid,
  output logic [R-1:0]     req_ready,
  input  logic [R*N-1:0]   req_a,
  input  logic [R*N-1:0]   req_b,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  input  logic [N-1:0]     add_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [N-1:0]     rsp_sum
);

  localparam logic [IDW-1:0] LAST_IDX = IDW'(R - 1);
  localparam logic [R-1:0]   ONE_HOT0 = {{(R-1){1'b0}}, 1'b1};

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [N-1:0]   rsp_sum_q, rsp_sum_d;

  logic           found_s;
  logic [IDW-1:0] grant_idx_s;
  logic           can_accept_s;
  logic           accept_s;

  // Round-robin scan starting at ptr; the first valid requester found wins.
  always_comb begin : grant_scan
    int             cand;
    logic [IDW-1:0] cand_idx;
    logic           hit;
    found_s     = 1'b0;
    grant_idx_s = '0;
    cand        = 0;
    cand_idx    = '0;
    hit         = 1'b0;
    for (int k = 0; k < R; k++) begin
      cand        = int'(ptr_q) + k;
      cand        = (cand >= R) ? (cand - R) : cand;
      cand_idx    = cand[IDW-1:0];
      hit         = !found_s && req_valid[cand_idx];
      grant_idx_s = hit ? cand_idx : grant_idx_s;
      found_s     = found_s | hit;
    end
  end

  // Handshake and operand steering; operands stay presented during a stall.
  always_comb begin
    can_accept_s = !rsp_valid_q || rsp_ready;
    accept_s     = found_s && can_accept_s;
    if (accept_s) begin
      req_ready = ONE_HOT0 << grant_idx_s;
    end else begin
      req_ready = '0;
    end
    if (found_s) begin
      add_a = req_a[int'(grant_idx_s) * N +: N];
      add_b = req_b[int'(grant_idx_s) * N +: N];
    end else begin
      add_a = '0;
      add_b = '0;
    end
  end

  // Next state of the pointer and output register.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    if (accept_s) begin
      // A drain and a new accept in the same cycle simply overwrite the entry.
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx_s;
      rsp_sum_d   = add_s;
      ptr_d       = (grant_idx_s == LAST_IDX) ? '0 : (grant_idx_s + IDW'(1));
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter (N=32, R=3). The bench models the shared
// adder; expected responses are pushed by the stimulus and popped by a monitor
// whenever the consumer takes a result.
module tb_adder_arbiter;

  localparam int N   = 32;
  localparam int R   = 3;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [R-1:0]   req_valid = '0;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a = '0;
  logic [R*N-1:0] req_b = '0;
  logic [N-1:0]   add_a, add_b, add_s;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IDW-1:0] rsp_id;
  logic [N-1:0]   rsp_sum;

  int vectors = 0;
  int errors  = 0;
  logic [IDW+N-1:0] exp_q[$];

  adder_arbiter #(.N(N), .R(R)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum)
  );

  // Shared combinational adder.
  assign add_s = add_a + add_b;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    resetn    = 1'b0;
    step();
    step();
    resetn    = 1'b1;
  endtask

  // Monitor: a result taken by the consumer is compared to the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {30'd0, rsp_id, rsp_sum}, 64'hDEAD);
        end else begin
          logic [IDW+N-1:0] e;
          e = exp_q.pop_front();
          chk("rsp_id", {62'd0, rsp_id}, {62'd0, e[IDW+N-1:N]});
          chk("rsp_sum", {32'd0, rsp_sum}, {32'd0, e[N-1:0]});
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    do_reset();
    @(negedge clk);
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_rsp_id", {62'd0, rsp_id}, 64'd0);
    chk("reset_rsp_sum", {32'd0, rsp_sum}, 64'd0);
    chk("reset_req_ready", {61'd0, req_ready}, 64'd0);
    chk("reset_add_a", {32'd0, add_a}, 64'd0);
    chk("reset_add_b", {32'd0, add_b}, 64'd0);

    // Single request from requester 1: 5 + 7.
    step();
    set_req(1, 32'd5, 32'd7);
    req_valid = 3'b010;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_req_ready", {61'd0, req_ready}, 64'd2);
    chk("single_add_a", {32'd0, add_a}, 64'd5);
    exp_q.push_back({2'd1, 32'd12});
    step();
    req_valid = '0;
    step();
    step();

    // Round-robin with all three valid from a fresh pointer.
    do_reset();
    set_req(0, 32'd10, 32'd1);
    set_req(1, 32'd100, 32'd20);
    set_req(2, 32'h0000_1000, 32'h0000_0234);
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    exp_q.push_back({2'd0, 32'd11});
    exp_q.push_back({2'd1, 32'd120});
    exp_q.push_back({2'd2, 32'h0000_1234});
    exp_q.push_back({2'd0, 32'd11});
    exp_q.push_back({2'd1, 32'd120});
    exp_q.push_back({2'd2, 32'h0000_1234});
    for (int c = 0; c < 6; c++) step();
    req_valid = '0;
    step();
    step();

    // Backpressure: fill with requester 0, then stall 4 cycles with requester 2 waiting.
    do_reset();
    set_req(0, 32'd3, 32'd4);
    set_req(2, 32'd50, 32'd60);
    req_valid = 3'b001;
    rsp_ready = 1'b0;
    exp_q.push_back({2'd0, 32'd7});
    step();
    req_valid = 3'b100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_req_ready", {61'd0, req_ready}, 64'd0);
      chk("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("stall_rsp_id", {62'd0, rsp_id}, 64'd0);
      chk("stall_rsp_sum", {32'd0, rsp_sum}, 64'd7);
      chk("stall_add_a", {32'd0, add_a}, 64'd50);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_req_ready", {61'd0, req_ready}, 64'd4);
    exp_q.push_back({2'd2, 32'd110});
    step();
    req_valid = '0;
    step();
    step();

    // Overflow wrap on two requesters.
    do_reset();
    set_req(0, 32'hFFFF_FFFF, 32'h0000_0002);
    set_req(1, 32'h8000_0000, 32'h8000_0000);
    req_valid = 3'b011;
    rsp_ready = 1'b1;
    exp_q.push_back({2'd0, 32'h0000_0001});
    exp_q.push_back({2'd1, 32'h0000_0000});
    step();
    req_valid = 3'b010;
    step();
    req_valid = '0;
    step();
    step();

    // Async reset while FULL with ptr=2; the held result is lost.
    do_reset();
    set_req(1, 32'd1, 32'd1);
    req_valid = 3'b010;
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    @(negedge clk);
    chk("pre_reset_full", {63'd0, rsp_valid}, 64'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("async_rst_sum", {32'd0, rsp_sum}, 64'd0);
    step();
    resetn = 1'b1;
    set_req(0, 32'd10, 32'd1);
    set_req(1, 32'd100, 32'd20);
    set_req(2, 32'h0000_1000, 32'h0000_0234);
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    exp_q.push_back({2'd0, 32'd11});
    step();
    req_valid = '0;
    step();
    step();

    // Idle drain: result taken with no new request keeps id/sum.
    do_reset();
    set_req(2, 32'd7, 32'd8);
    req_valid = 3'b100;
    rsp_ready = 1'b0;
    exp_q.push_back({2'd2, 32'd15});
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("drain_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("drain_rsp_id", {62'd0, rsp_id}, 64'd2);
    chk("drain_rsp_sum", {32'd0, rsp_sum}, 64'd15);
    step();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
